fp_issue_scheduler: RTL

//  Issue/writeback scheduler for the pipelined FP ALU (add/sub, mul, div, sqrt units).

---
 rtl/fp_issue_scheduler_if.sv | 30 +++
 rtl/fp_issue_scheduler.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fp_issue_scheduler_if.sv
// Issue / writeback bundle between the FP decode stage and the FP issue scheduler.
// The decoder drives the issue request; the scheduler answers with the
// acceptance, the writeback tag stream and the scoreboard view.
interface fp_issue_scheduler_if #(
    parameter int REG_AW = 5
) ();
    logic                     IssueValid;
    logic [1:0]               IssueUnit;
    logic [REG_AW-1:0]        IssueDest;
    logic [REG_AW-1:0]        IssueSrc1;
    logic [REG_AW-1:0]        IssueSrc2;
    logic                     IssueReady;
    logic                     WbValid;
    logic [1:0]               WbUnit;
    logic [REG_AW-1:0]        WbDest;
    logic [(1<<REG_AW)-1:0]   Busy;
    logic [5:0]               InFlight;

    // Decoder side: presents ops, observes acceptance and writeback tags.
    modport master (
        output IssueValid, IssueUnit, IssueDest, IssueSrc1, IssueSrc2,
        input  IssueReady, WbValid, WbUnit, WbDest, Busy, InFlight
    );

    // Scheduler side.
    modport slave (
        input  IssueValid, IssueUnit, IssueDest, IssueSrc1, IssueSrc2,
        output IssueReady, WbValid, WbUnit, WbDest, Busy, InFlight
    );
endinterface

// File: rtl/fp_issue_scheduler.sv
// FP issue / writeback scheduler.
// Gates each decoded FP op on a register scoreboard (RAW/WAW), a shared
// writeback-port reservation ring and the divider initiation interval, and
// replays the destination tag of every accepted op in the exact cycle its
// unit result appears.
module fp_issue_scheduler #(
    parameter int REG_AW   = 5,
    parameter int LAT_ADD  = 7,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 20,
    parameter int LAT_SQRT = 16,
    parameter int DIV_II   = 4,
    parameter int MAX_LAT  = 20
) (
    input  logic                 clock,
    input  logic                 nReset,
    fp_issue_scheduler_if.slave  bus
);

    localparam int NREG = 1 << REG_AW;
    localparam int LW   = $clog2(MAX_LAT + 2);
    localparam int DCW  = (DIV_II > 1) ? $clog2(DIV_II) : 1;

    // Latency of a functional unit; the ring slot index used for its reservation.
    function automatic logic [LW-1:0] lat_of(input logic [1:0] unit);
        logic [LW-1:0] lat;
        case (unit)
            2'd0:    lat = LW'(LAT_ADD);
            2'd1:    lat = LW'(LAT_MUL);
            2'd2:    lat = LW'(LAT_DIV);
            2'd3:    lat = LW'(LAT_SQRT);
            default: lat = LW'(LAT_ADD);
        endcase
        return lat;
    endfunction

    // Reservation ring: slot i holds the op whose result is valid i cycles from now.
    logic              slot_valid_q [0:MAX_LAT];
    logic [1:0]        slot_unit_q  [0:MAX_LAT];
    logic [REG_AW-1:0] slot_dest_q  [0:MAX_LAT];
    logic              slot_valid_d [0:MAX_LAT];
    logic [1:0]        slot_unit_d  [0:MAX_LAT];
    logic [REG_AW-1:0] slot_dest_d  [0:MAX_LAT];

    logic [NREG-1:0]   busy_q, busy_d;
    logic [DCW-1:0]    div_cnt_q, div_cnt_d;
    logic [5:0]        inflight_q, inflight_d;

    logic [LW-1:0]     lat_s;
    logic              src2_ok_s;
    logic              div_ok_s;
    logic              ready_s;
    logic              accept_s;
    logic              wb_valid_s;
    logic [NREG-1:0]   set_mask_s;
    logic [NREG-1:0]   clr_mask_s;

    // Issue gate: hazards are judged on registered state only, no bypass.
    always_comb begin
        lat_s     = lat_of(bus.IssueUnit);
        src2_ok_s = (bus.IssueUnit == 2'd3) ? 1'b1 : ~busy_q[bus.IssueSrc2];
        div_ok_s  = (bus.IssueUnit != 2'd2) || (div_cnt_q == {DCW{1'b0}});
        ready_s   = ~busy_q[bus.IssueSrc1] & src2_ok_s & ~busy_q[bus.IssueDest]
                  & ~slot_valid_q[lat_s] & div_ok_s;
        accept_s  = bus.IssueValid & ready_s;
    end

    // Ring advance by one slot; an accepted op lands in slot L-1, which the shift left empty.
    always_comb begin
        for (int i = 0; i < MAX_LAT; i++) begin
            slot_valid_d[i] = (accept_s && (lat_s == LW'(i + 1))) ? 1'b1          : slot_valid_q[i + 1];
            slot_unit_d[i]  = (accept_s && (lat_s == LW'(i + 1))) ? bus.IssueUnit : slot_unit_q[i + 1];
            slot_dest_d[i]  = (accept_s && (lat_s == LW'(i + 1))) ? bus.IssueDest : slot_dest_q[i + 1];
        end
        slot_valid_d[MAX_LAT] = 1'b0;
        slot_unit_d[MAX_LAT]  = 2'd0;
        slot_dest_d[MAX_LAT]  = {REG_AW{1'b0}};
    end

    // Scoreboard: new issue sets its destination, writeback clears; set wins on overlap.
    always_comb begin
        wb_valid_s = slot_valid_q[0];
        set_mask_s = accept_s   ? (NREG'(1) << bus.IssueDest)      : {NREG{1'b0}};
        clr_mask_s = wb_valid_s ? (NREG'(1) << slot_dest_q[0])     : {NREG{1'b0}};
        busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
    end

    // Divider initiation-interval counter.
    always_comb begin
        if (accept_s && (bus.IssueUnit == 2'd2)) begin
            div_cnt_d = DCW'(DIV_II - 1);
        end else if (div_cnt_q != {DCW{1'b0}}) begin
            div_cnt_d = div_cnt_q - DCW'(1);
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Count of accepted ops whose writeback has not happened yet.
    always_comb begin
        case ({accept_s, wb_valid_s})
            2'b10:   inflight_d = inflight_q + 6'd1;
            2'b01:   inflight_d = inflight_q - 6'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; async reset discards every in-flight tag.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i <= MAX_LAT; i++) begin
                slot_valid_q[i] <= 1'b0;
                slot_unit_q[i]  <= 2'd0;
                slot_dest_q[i]  <= {REG_AW{1'b0}};
            end
            busy_q     <= {NREG{1'b0}};
            div_cnt_q  <= {DCW{1'b0}};
            inflight_q <= 6'd0;
        end else begin
            for (int i = 0; i <= MAX_LAT; i++) begin
                slot_valid_q[i] <= slot_valid_d[i];
                slot_unit_q[i]  <= slot_unit_d[i];
                slot_dest_q[i]  <= slot_dest_d[i];
            end
            busy_q     <= busy_d;
            div_cnt_q  <= div_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // Outputs: writeback tag straight from ring slot 0, scoreboard and count from flops.
    always_comb begin
        bus.IssueReady = ready_s;
        bus.WbValid    = slot_valid_q[0];
        bus.WbUnit     = slot_unit_q[0];
        bus.WbDest     = slot_dest_q[0];
        bus.Busy       = busy_q;
        bus.InFlight   = inflight_q;
    end

endmodule
